// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: the dispatch row, stored entry, retire record and
// sizing constants, plus helpers used by the retire selector.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int IDX_W     = $clog2(ROB_DEPTH);
    localparam int NUM_FU    = 3;
    localparam int WORD_W    = 32;
    localparam int PREG_W    = 6;

    typedef logic [IDX_W-1:0]  rob_idx;
    typedef logic [IDX_W:0]    rob_cnt;
    typedef logic [WORD_W-1:0] word;
    typedef logic [PREG_W-1:0] p_reg;

    typedef struct packed {
        logic   valid;
        rob_idx rob_number;
        p_reg   preg_dst;
        p_reg   old_preg_dst;
        logic   reg_write;
        logic   mem_write;
    } rob_row_struct;

    typedef struct packed {
        logic valid;
        logic complete;
        p_reg preg_dst;
        p_reg old_preg_dst;
        logic reg_write;
        logic mem_write;
        word  data;
    } rob_entry_struct;

    typedef struct packed {
        logic   valid;
        rob_idx rob;
        p_reg   dst;
        word    data;
        logic   regwrite;
        logic   memwrite;
        logic   free_valid;
        p_reg   free_preg;
    } retire_struct;

    function automatic logic entry_ready(input rob_entry_struct e);
        return e.valid && e.complete;
    endfunction

    // Physical register 0 is never returned to the free pool.
    function automatic retire_struct make_retire(input logic en, input rob_idx idx,
                                                 input rob_entry_struct e);
        retire_struct r;
        r.valid      = en;
        r.rob        = idx;
        r.dst        = e.preg_dst;
        r.data       = e.data;
        r.regwrite   = e.reg_write;
        r.memwrite   = e.mem_write;
        r.free_valid = en && e.reg_write && (e.old_preg_dst != '0);
        r.free_preg  = e.old_preg_dst;
        return r;
    endfunction

endpackage

// File: rtl/reorder_buffer_retire_select.sv
// Combinational retire selection for the two oldest entries; slot 1 only retires when
// DUAL_RETIRE is set and never carries a store.
module rob_retire_select
    import reorder_buffer_pkg::*;
#(
    parameter bit DUAL_RETIRE = 1'b0
) (
    input  rob_idx          head,
    input  rob_entry_struct cand0,
    input  rob_entry_struct cand1,
    output logic [1:0]      retire_en,
    output logic [1:0]      retire_cnt,
    output retire_struct    retire_rec [0:1]
);

    always_comb begin
        retire_en     = '0;
        retire_en[0]  = entry_ready(cand0);
        retire_en[1]  = DUAL_RETIRE && retire_en[0] && entry_ready(cand1) && !cand1.mem_write;
        retire_cnt    = {1'b0, retire_en[0]} + {1'b0, retire_en[1]};
        retire_rec[0] = make_retire(retire_en[0], head, cand0);
        retire_rec[1] = make_retire(retire_en[1], head + rob_idx'(1), cand1);
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement tracker for up to two dispatched rows per cycle and three completion
// ports. Define ROB_DUAL_RETIRE_EN for two-wide retire; otherwise only slot 0 retires.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  rob_row_struct i_rob_rows        [0:1],
    input  logic          i_cmp_valid       [0:NUM_FU-1],
    input  rob_idx        i_cmp_rob         [0:NUM_FU-1],
    input  word           i_cmp_data        [0:NUM_FU-1],
    output logic          o_stall,
    output logic          o_retire_valid    [0:1],
    output rob_idx        o_retire_rob      [0:1],
    output p_reg          o_retire_dst      [0:1],
    output word           o_retire_data     [0:1],
    output logic          o_retire_regwrite [0:1],
    output logic          o_retire_memwrite [0:1],
    output logic          o_free_preg_valid [0:1],
    output p_reg          o_free_preg       [0:1],
    output logic          o_overflow,
    output logic          o_seq_error
);

`ifdef ROB_DUAL_RETIRE_EN
    localparam bit DUAL_RETIRE = 1'b1;
`else
    localparam bit DUAL_RETIRE = 1'b0;
`endif

    rob_entry_struct entries   [ROB_DEPTH];
    rob_entry_struct entries_n [ROB_DEPTH];
    rob_idx          head, head_n, head_p1, tail, tail_n;
    rob_cnt          count, count_n, room;
    logic            overflow, overflow_n, seq_err, seq_err_n;
    logic [1:0]      ret_en, ret_cnt, alloc_cnt;
    retire_struct    ret_rec [0:1];
    retire_struct    ret_q   [0:1];

    assign head_p1 = head + rob_idx'(1);

    rob_retire_select #(
        .DUAL_RETIRE (DUAL_RETIRE)
    ) u_retire_select (
        .head       (head),
        .cand0      (entries[head]),
        .cand1      (entries[head_p1]),
        .retire_en  (ret_en),
        .retire_cnt (ret_cnt),
        .retire_rec (ret_rec)
    );

    // Update order within one edge: retire frees slots first, then allocation, then
    // completion, so a same-edge allocate+complete lands on the freshly written entry.
    always_comb begin
        entries_n  = entries;
        head_n     = head + rob_idx'(ret_cnt);
        tail_n     = tail;
        overflow_n = overflow;
        seq_err_n  = seq_err;
        alloc_cnt  = '0;
        room       = rob_cnt'(ROB_DEPTH) - count + rob_cnt'(ret_cnt);

        if (ret_en[0]) entries_n[head]    = '0;
        if (ret_en[1]) entries_n[head_p1] = '0;

        for (int k = 0; k < 2; k++) begin
            if (i_rob_rows[k].valid) begin
                if (room != '0) begin
                    entries_n[i_rob_rows[k].rob_number].valid        = 1'b1;
                    entries_n[i_rob_rows[k].rob_number].complete     = 1'b0;
                    entries_n[i_rob_rows[k].rob_number].preg_dst     = i_rob_rows[k].preg_dst;
                    entries_n[i_rob_rows[k].rob_number].old_preg_dst = i_rob_rows[k].old_preg_dst;
                    entries_n[i_rob_rows[k].rob_number].reg_write    = i_rob_rows[k].reg_write;
                    entries_n[i_rob_rows[k].rob_number].mem_write    = i_rob_rows[k].mem_write;
                    entries_n[i_rob_rows[k].rob_number].data         = '0;
                    if (i_rob_rows[k].rob_number != tail_n) seq_err_n = 1'b1;
                    tail_n    = tail_n + rob_idx'(1);
                    alloc_cnt = alloc_cnt + 2'd1;
                    room      = room - rob_cnt'(1);
                end else begin
                    overflow_n = 1'b1;
                end
            end
        end

        // Ascending port order lets the higher-numbered port win a same-entry collision.
        for (int p = 0; p < NUM_FU; p++) begin
            if (i_cmp_valid[p] && entries_n[i_cmp_rob[p]].valid) begin
                entries_n[i_cmp_rob[p]].complete = 1'b1;
                entries_n[i_cmp_rob[p]].data     = i_cmp_data[p];
            end
        end

        count_n = count + rob_cnt'(alloc_cnt) - rob_cnt'(ret_cnt);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            entries  <= '{default: '0};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            seq_err  <= 1'b0;
            ret_q    <= '{default: '0};
        end else begin
            entries  <= entries_n;
            head     <= head_n;
            tail     <= tail_n;
            count    <= count_n;
            overflow <= overflow_n;
            seq_err  <= seq_err_n;
            ret_q    <= ret_rec;
        end
    end

    // Dispatch presents rows only while o_stall is low; a row offered with no free slot
    // is dropped and flagged on o_overflow instead of being back-pressured.
    assign o_stall     = (rob_cnt'(ROB_DEPTH) - count) < rob_cnt'(2);
    assign o_overflow  = overflow;
    assign o_seq_error = seq_err;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            o_retire_valid[k]    = ret_q[k].valid;
            o_retire_rob[k]      = ret_q[k].rob;
            o_retire_dst[k]      = ret_q[k].dst;
            o_retire_data[k]     = ret_q[k].data;
            o_retire_regwrite[k] = ret_q[k].regwrite;
            o_retire_memwrite[k] = ret_q[k].memwrite;
            o_free_preg_valid[k] = ret_q[k].free_valid;
            o_free_preg[k]       = ret_q[k].free_preg;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: expected retire records are queued at dispatch
// and compared in order as the buffer retires them.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

`ifdef ROB_DUAL_RETIRE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif
    localparam int REC_W = IDX_W + PREG_W + WORD_W + 3 + PREG_W;

    logic          i_clk;
    logic          i_rst_n;
    rob_row_struct i_rob_rows        [0:1];
    logic          i_cmp_valid       [0:NUM_FU-1];
    rob_idx        i_cmp_rob         [0:NUM_FU-1];
    word           i_cmp_data        [0:NUM_FU-1];
    logic          o_stall;
    logic          o_retire_valid    [0:1];
    rob_idx        o_retire_rob      [0:1];
    p_reg          o_retire_dst      [0:1];
    word           o_retire_data     [0:1];
    logic          o_retire_regwrite [0:1];
    logic          o_retire_memwrite [0:1];
    logic          o_free_preg_valid [0:1];
    p_reg          o_free_preg       [0:1];
    logic          o_overflow;
    logic          o_seq_error;

    logic [REC_W-1:0] exp_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;

    reorder_buffer dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_rob_rows        (i_rob_rows),
        .i_cmp_valid       (i_cmp_valid),
        .i_cmp_rob         (i_cmp_rob),
        .i_cmp_data        (i_cmp_data),
        .o_stall           (o_stall),
        .o_retire_valid    (o_retire_valid),
        .o_retire_rob      (o_retire_rob),
        .o_retire_dst      (o_retire_dst),
        .o_retire_data     (o_retire_data),
        .o_retire_regwrite (o_retire_regwrite),
        .o_retire_memwrite (o_retire_memwrite),
        .o_free_preg_valid (o_free_preg_valid),
        .o_free_preg       (o_free_preg),
        .o_overflow        (o_overflow),
        .o_seq_error       (o_seq_error)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] pack_rec(input rob_idx rob, input p_reg dst,
                                                  input word data, input logic rw,
                                                  input logic mw, input p_reg old);
        logic fv;
        fv = rw && (old != '0);
        return {rob, dst, data, rw, mw, fv, fv ? old : p_reg'(0)};
    endfunction

    function automatic logic [1:0] ret_pat();
        return {o_retire_valid[0], o_retire_valid[1]};
    endfunction

    // driver tasks
    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) i_rob_rows[k] = '0;
        for (int p = 0; p < NUM_FU; p++) begin
            i_cmp_valid[p] = 1'b0;
            i_cmp_rob[p]   = '0;
            i_cmp_data[p]  = '0;
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        clear_inputs();
    endtask

    task automatic stage_row(input int k, input int rob, input int dst, input int old,
                             input bit rw, input bit mw, input word data, input bit exp_retire);
        i_rob_rows[k].valid        = 1'b1;
        i_rob_rows[k].rob_number   = rob_idx'(rob);
        i_rob_rows[k].preg_dst     = p_reg'(dst);
        i_rob_rows[k].old_preg_dst = p_reg'(old);
        i_rob_rows[k].reg_write    = rw;
        i_rob_rows[k].mem_write    = mw;
        if (exp_retire)
            exp_q.push_back(pack_rec(rob_idx'(rob), p_reg'(dst), data, rw, mw, p_reg'(old)));
    endtask

    task automatic stage_cmp(input int p, input int rob, input word data);
        i_cmp_valid[p] = 1'b1;
        i_cmp_rob[p]   = rob_idx'(rob);
        i_cmp_data[p]  = data;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge i_clk);
            n++;
        end
        repeat (3) @(posedge i_clk);
        #1;
        check_value(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard
    always @(negedge i_clk) begin
        logic [REC_W-1:0] obs;
        logic [REC_W-1:0] e;
        if (i_rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (o_retire_valid[k]) begin
                    obs = {o_retire_rob[k], o_retire_dst[k], o_retire_data[k],
                           o_retire_regwrite[k], o_retire_memwrite[k], o_free_preg_valid[k],
                           o_free_preg_valid[k] ? o_free_preg[k] : p_reg'(0)};
                    if (exp_q.size() == 0) begin
                        check_value("unexpected_retire", 64'(obs), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_value(k == 0 ? "retire_slot0" : "retire_slot1", 64'(obs), 64'(e));
                    end
                end
            end
            if (o_retire_valid[1]) check_value("slot1_store", 64'(o_retire_memwrite[1]), 64'd0);
            if (!DUAL && (o_retire_valid[1] || o_free_preg_valid[1]))
                check_value("slot1_tied", 64'd1, 64'd0);
        end
    end

    initial begin
        word d;
        i_rst_n = 1'b1;
        clear_inputs();
        #2 i_rst_n = 1'b0;
        #1;
        check_value("reset_retire", 64'(ret_pat()), 64'd0);
        check_value("reset_free", 64'({o_free_preg_valid[0], o_free_preg_valid[1]}), 64'd0);
        check_value("reset_stall", 64'(o_stall), 64'd0);
        check_value("reset_overflow", 64'(o_overflow), 64'd0);
        check_value("reset_seq", 64'(o_seq_error), 64'd0);
        do_reset();

        // single ALU op, completion latency
        stage_row(0, 0, 40, 5, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
        tick();
        stage_cmp(0, 0, 32'hDEADBEEF);
        tick();
        @(negedge i_clk);
        check_value("latency_early", 64'(ret_pat()), 64'd0);
        @(negedge i_clk);
        check_value("latency_retire", 64'(ret_pat()), 64'b10);
        check_value("free_preg_5", 64'(o_free_preg[0]), 64'd5);
        drain("single_drain");

        // out-of-order completion, paired retire
        do_reset();
        stage_row(0, 0, 10, 2, 1'b1, 1'b0, 32'h11110000, 1'b1);
        stage_row(1, 1, 11, 3, 1'b1, 1'b0, 32'h22220001, 1'b1);
        tick();
        stage_cmp(0, 1, 32'h22220001);
        tick();
        @(negedge i_clk);
        check_value("pair_wait", 64'(ret_pat()), 64'd0);
        stage_cmp(1, 0, 32'h11110000);
        tick();
        @(negedge i_clk);
        check_value("pair_early", 64'(ret_pat()), 64'd0);
        @(negedge i_clk);
        check_value("pair_retire", 64'(ret_pat()), DUAL ? 64'b11 : 64'b10);
        drain("pair_drain");

        // two stores retire one per cycle in slot 0
        do_reset();
        stage_row(0, 0, 20, 0, 1'b0, 1'b1, 32'h0000A0A0, 1'b1);
        stage_row(1, 1, 21, 0, 1'b0, 1'b1, 32'h0000B1B1, 1'b1);
        tick();
        stage_cmp(0, 0, 32'h0000A0A0);
        stage_cmp(1, 1, 32'h0000B1B1);
        tick();
        @(negedge i_clk);
        check_value("store_early", 64'(ret_pat()), 64'd0);
        @(negedge i_clk);
        check_value("store_first", 64'(ret_pat()), 64'b10);
        @(negedge i_clk);
        check_value("store_second", 64'(ret_pat()), 64'b10);
        drain("store_drain");

        // fill, stall, overflow
        do_reset();
        for (int i = 0; i < 7; i++) begin
            stage_row(0, 2 * i, 30 + i, i + 1, 1'b1, 1'b0, 32'hA0000000 + 32'(2 * i), 1'b1);
            stage_row(1, 2 * i + 1, 40 + i, 0, 1'b1, 1'b0, 32'hA0000000 + 32'(2 * i + 1), 1'b1);
            tick();
        end
        @(negedge i_clk);
        check_value("stall_at_14", 64'(o_stall), 64'd0);
        stage_row(0, 14, 50, 9, 1'b1, 1'b0, 32'hA000000E, 1'b1);
        tick();
        @(negedge i_clk);
        check_value("stall_at_15", 64'(o_stall), 64'd1);
        stage_row(0, 15, 51, 10, 1'b1, 1'b0, 32'hA000000F, 1'b1);
        tick();
        @(negedge i_clk);
        check_value("overflow_at_16", 64'(o_overflow), 64'd0);
        stage_row(0, 0, 60, 11, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        @(negedge i_clk);
        check_value("overflow_17th", 64'(o_overflow), 64'd1);
        check_value("stall_full", 64'(o_stall), 64'd1);
        check_value("seq_full", 64'(o_seq_error), 64'd0);
        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < NUM_FU; p++)
                if (3 * i + p < 16) stage_cmp(p, 3 * i + p, 32'hA0000000 + 32'(3 * i + p));
            tick();
        end
        drain("full_drain");
        check_value("overflow_sticky", 64'(o_overflow), 64'd1);
        check_value("stall_empty", 64'(o_stall), 64'd0);
        stage_row(0, 0, 61, 12, 1'b1, 1'b0, 32'h0BADF00D, 1'b1);
        stage_cmp(2, 0, 32'h0BADF00D);
        tick();
        drain("after_full_drain");
        check_value("tail_after_overflow", 64'(o_seq_error), 64'd0);

        // wrap-around: alloc+complete on the same edge every cycle
        do_reset();
        check_value("overflow_cleared", 64'(o_overflow), 64'd0);
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            stage_row(0, i % 16, 16 + i, i % 3, (i % 4) != 3, (i % 5) == 4, d, 1'b1);
            stage_cmp($urandom_range(0, NUM_FU - 1), i % 16, d);
            tick();
        end
        drain("wrap_drain");
        check_value("wrap_seq", 64'(o_seq_error), 64'd0);
        check_value("wrap_overflow", 64'(o_overflow), 64'd0);

        // completion to invalid entry, port collision
        do_reset();
        stage_cmp(1, 0, 32'h00001234);
        tick();
        stage_row(0, 0, 12, 3, 1'b1, 1'b0, 32'h00000055, 1'b1);
        tick();
        repeat (4) @(posedge i_clk);
        #1;
        check_value("no_spurious_retire", 64'(exp_q.size()), 64'd1);
        stage_cmp(0, 0, 32'h00000BAD);
        stage_cmp(2, 0, 32'h00000055);
        tick();
        drain("collision_drain");

        // out-of-sequence ROBNumber, async reset clears the sticky flag
        do_reset();
        stage_row(0, 3, 20, 7, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        @(negedge i_clk);
        check_value("seq_error_set", 64'(o_seq_error), 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check_value("seq_cleared_by_reset", 64'(o_seq_error), 64'd0);
        do_reset();

        // reset with six entries pending
        for (int i = 0; i < 3; i++) begin
            stage_row(0, 2 * i, 33 + i, i + 1, 1'b1, 1'b0, 32'hC0000000 + 32'(2 * i), 1'b1);
            stage_row(1, 2 * i + 1, 43 + i, i + 4, 1'b1, 1'b0, 32'hC0000000 + 32'(2 * i + 1), 1'b1);
            tick();
        end
        for (int p = 0; p < NUM_FU; p++) stage_cmp(p, p + 1, 32'hC0000000 + 32'(p + 1));
        tick();
        stage_cmp(0, 4, 32'hC0000004);
        stage_cmp(1, 5, 32'hC0000005);
        tick();
        stage_cmp(0, 0, 32'hC0000000);
        tick();
        @(posedge i_clk);
        #1;
        check_value("pre_reset_valid", 64'(o_retire_valid[0]), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check_value("rst_retire", 64'(ret_pat()), 64'd0);
        check_value("rst_free", 64'({o_free_preg_valid[0], o_free_preg_valid[1]}), 64'd0);
        check_value("rst_stall", 64'(o_stall), 64'd0);
        exp_q.delete();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            check_value("post_reset_idle", 64'(ret_pat()), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
